// File: rtl/dma_stream_ctrl_2d_pkg.sv
// rtl/dma_stream_ctrl_2d_pkg.sv - shared state encoding and defaults for the 2D DMA stream sequencer
package dma_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int DEF_RESTART_DELAY = 3;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } plane_state_e;

endpackage

// File: rtl/dma_stream_ctrl_2d_if.sv
// rtl/dma_stream_ctrl_2d_if.sv - burst handshake between the sequencer and the dma_rd/dma_wr engines
interface dma_stream_ctrl_2d_if #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int BIT_TRANS    = 18
);
  logic                    ctrl_read;
  logic [AXI_WIDTH_AD-1:0] read_addr;
  logic                    read_done;
  logic                    ctrl_write;
  logic [AXI_WIDTH_AD-1:0] write_addr;
  logic [BIT_TRANS-1:0]    write_data_cnt;
  logic                    write_done;
  logic                    indata_req_wr;

  modport master (
    output ctrl_read, read_addr, ctrl_write, write_addr, write_data_cnt,
    input  read_done, write_done, indata_req_wr
  );

  modport slave (
    input  ctrl_read, read_addr, ctrl_write, write_addr, write_data_cnt,
    output read_done, write_done, indata_req_wr
  );
endinterface

// File: rtl/dma_stream_ctrl_2d_plane_seq.sv
// rtl/dma_stream_ctrl_2d_plane_seq.sv - one plane: FSM, block/row counters, address accumulators, gap timer
module dma_plane_seq
  import dma_pkg::*;
#(
  parameter int AXI_WIDTH_AD  = 32,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RESTART_DELAY = DEF_RESTART_DELAY
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    abort_i,
  input  logic                    start_i,
  input  logic [AXI_WIDTH_AD-1:0] base_addr_i,
  input  logic [CNT_W-1:0]        num_blk_i,
  input  logic [CNT_W-1:0]        num_row_i,
  input  logic [AXI_WIDTH_AD-1:0] blk_stride_i,
  input  logic [AXI_WIDTH_AD-1:0] row_stride_i,
  input  logic                    burst_done_i,
  output logic                    req_o,
  output logic [AXI_WIDTH_AD-1:0] addr_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int GAP_W = (RESTART_DELAY > 1) ? $clog2(RESTART_DELAY) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((RESTART_DELAY > 0) ? RESTART_DELAY - 1 : 0);

  plane_state_e            state_q, state_d;
  logic [CNT_W-1:0]        blk_q, blk_d, row_q, row_d;
  logic [CNT_W-1:0]        nblk_q, nblk_d, nrow_q, nrow_d;
  logic [AXI_WIDTH_AD-1:0] bstr_q, bstr_d, rstr_q, rstr_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d, row_addr_q, row_addr_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    last_blk, last_row;

  assign last_blk = (blk_q == nblk_q - CNT_W'(1));
  assign last_row = (row_q == nrow_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      row_q      <= '0;
      nblk_q     <= '0;
      nrow_q     <= '0;
      bstr_q     <= '0;
      rstr_q     <= '0;
      addr_q     <= '0;
      row_addr_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      row_q      <= row_d;
      nblk_q     <= nblk_d;
      nrow_q     <= nrow_d;
      bstr_q     <= bstr_d;
      rstr_q     <= rstr_d;
      addr_q     <= addr_d;
      row_addr_q <= row_addr_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    row_d      = row_q;
    nblk_d     = nblk_q;
    nrow_d     = nrow_q;
    bstr_d     = bstr_q;
    rstr_d     = rstr_q;
    addr_d     = addr_q;
    row_addr_d = row_addr_q;
    gap_d      = gap_q;
    if (abort_i) begin
      state_d    = S_IDLE;
      blk_d      = '0;
      row_d      = '0;
      addr_d     = '0;
      row_addr_d = '0;
      gap_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          nblk_d     = num_blk_i;
          nrow_d     = num_row_i;
          bstr_d     = blk_stride_i;
          rstr_d     = row_stride_i;
          addr_d     = base_addr_i;
          row_addr_d = base_addr_i;
          blk_d      = '0;
          row_d      = '0;
          state_d    = (num_blk_i == '0 || num_row_i == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: if (burst_done_i) begin
          if (last_blk && last_row) begin
            state_d = S_DONE;
          end else begin
            // Row wrap restarts from the row accumulator so strides never need a multiply
            if (last_blk) begin
              blk_d      = '0;
              row_d      = row_q + CNT_W'(1);
              row_addr_d = row_addr_q + rstr_q;
              addr_d     = row_addr_q + rstr_q;
            end else begin
              blk_d  = blk_q + CNT_W'(1);
              addr_d = addr_q + bstr_q;
            end
            gap_d   = '0;
            state_d = (RESTART_DELAY == 0) ? S_ISSUE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_d = S_ISSUE;
          else                   gap_d   = gap_q + GAP_W'(1);
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign req_o  = (state_q == S_ISSUE);
  assign done_o = (state_q == S_DONE);
  assign busy_o = (state_q != S_IDLE);
  assign addr_o = addr_q;

endmodule

// File: rtl/dma_stream_ctrl_2d.sv
// rtl/dma_stream_ctrl_2d.sv - dual-plane 2D DMA stream sequencer with write beat counter and abort fan-out
module dma_stream_ctrl_2d
  import dma_pkg::*;
#(
  parameter int AXI_WIDTH_AD  = 32,
  parameter int BIT_TRANS     = 18,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RESTART_DELAY = DEF_RESTART_DELAY
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_rd_start,
  input  logic [AXI_WIDTH_AD-1:0] i_rd_base_addr,
  input  logic [CNT_W-1:0]        i_rd_num_blk,
  input  logic [CNT_W-1:0]        i_rd_num_row,
  input  logic [AXI_WIDTH_AD-1:0] i_rd_blk_stride,
  input  logic [AXI_WIDTH_AD-1:0] i_rd_row_stride,
  output logic                    o_rd_busy,
  output logic                    o_ctrl_read_done,
  input  logic                    i_wr_start,
  input  logic [AXI_WIDTH_AD-1:0] i_wr_base_addr,
  input  logic [CNT_W-1:0]        i_wr_num_blk,
  input  logic [CNT_W-1:0]        i_wr_num_row,
  input  logic [AXI_WIDTH_AD-1:0] i_wr_blk_stride,
  input  logic [AXI_WIDTH_AD-1:0] i_wr_row_stride,
  input  logic [BIT_TRANS-1:0]    i_wr_num_trans,
  output logic                    o_wr_busy,
  output logic                    o_ctrl_write_done,
  input  logic                    i_abort,
  dma_stream_ctrl_2d_if.master    dma_if
);

  logic                 wr_req;
  logic [BIT_TRANS-1:0] ntr_q, ntr_d, cnt_q, cnt_d;

  dma_plane_seq #(.AXI_WIDTH_AD(AXI_WIDTH_AD), .CNT_W(CNT_W), .RESTART_DELAY(RESTART_DELAY)) u_rd (
    .clk, .rstn, .abort_i(i_abort), .start_i(i_rd_start), .base_addr_i(i_rd_base_addr),
    .num_blk_i(i_rd_num_blk), .num_row_i(i_rd_num_row), .blk_stride_i(i_rd_blk_stride),
    .row_stride_i(i_rd_row_stride), .burst_done_i(dma_if.read_done), .req_o(dma_if.ctrl_read),
    .addr_o(dma_if.read_addr), .busy_o(o_rd_busy), .done_o(o_ctrl_read_done)
  );

  dma_plane_seq #(.AXI_WIDTH_AD(AXI_WIDTH_AD), .CNT_W(CNT_W), .RESTART_DELAY(RESTART_DELAY)) u_wr (
    .clk, .rstn, .abort_i(i_abort), .start_i(i_wr_start), .base_addr_i(i_wr_base_addr),
    .num_blk_i(i_wr_num_blk), .num_row_i(i_wr_num_row), .blk_stride_i(i_wr_blk_stride),
    .row_stride_i(i_wr_row_stride), .burst_done_i(dma_if.write_done), .req_o(wr_req),
    .addr_o(dma_if.write_addr), .busy_o(o_wr_busy), .done_o(o_ctrl_write_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ntr_q <= '0;
      cnt_q <= '0;
    end else begin
      ntr_q <= ntr_d;
      cnt_q <= cnt_d;
    end
  end

  // Beat count is latched alongside the plane config, i.e. only when the write plane accepts a start
  always_comb begin
    ntr_d = ntr_q;
    cnt_d = cnt_q;
    if (i_abort) begin
      cnt_d = '0;
    end else begin
      if (i_wr_start && !o_wr_busy) ntr_d = i_wr_num_trans;
      if (wr_req) begin
        cnt_d = '0;
      end else if (dma_if.indata_req_wr) begin
        if (ntr_q == '0 || cnt_q == ntr_q - BIT_TRANS'(1)) cnt_d = '0;
        else                                               cnt_d = cnt_q + BIT_TRANS'(1);
      end
    end
  end

  assign dma_if.ctrl_write     = wr_req;
  assign dma_if.write_data_cnt = cnt_q;

endmodule

// File: tb/tb_dma_stream_ctrl_2d.sv
// tb/tb_dma_stream_ctrl_2d.sv - directed self-checking bench for dma_stream_ctrl_2d
module tb_dma_stream_ctrl_2d;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_rd_start, i_wr_start, i_abort;
  logic [31:0] i_rd_base_addr, i_rd_blk_stride, i_rd_row_stride;
  logic [31:0] i_wr_base_addr, i_wr_blk_stride, i_wr_row_stride;
  logic [15:0] i_rd_num_blk, i_rd_num_row, i_wr_num_blk, i_wr_num_row;
  logic [17:0] i_wr_num_trans;
  logic        o_rd_busy, o_ctrl_read_done, o_wr_busy, o_ctrl_write_done;
  int          checks = 0;
  int          failures = 0;
  int          n;
  logic [31:0] wr_exp [4];

  dma_stream_ctrl_2d_if #(.AXI_WIDTH_AD(32), .BIT_TRANS(18)) dma_if ();

  dma_stream_ctrl_2d #(.AXI_WIDTH_AD(32), .BIT_TRANS(18), .CNT_W(16), .RESTART_DELAY(3)) dut (
    .clk(clk), .rstn(rstn),
    .i_rd_start(i_rd_start), .i_rd_base_addr(i_rd_base_addr), .i_rd_num_blk(i_rd_num_blk),
    .i_rd_num_row(i_rd_num_row), .i_rd_blk_stride(i_rd_blk_stride), .i_rd_row_stride(i_rd_row_stride),
    .o_rd_busy(o_rd_busy), .o_ctrl_read_done(o_ctrl_read_done),
    .i_wr_start(i_wr_start), .i_wr_base_addr(i_wr_base_addr), .i_wr_num_blk(i_wr_num_blk),
    .i_wr_num_row(i_wr_num_row), .i_wr_blk_stride(i_wr_blk_stride), .i_wr_row_stride(i_wr_row_stride),
    .i_wr_num_trans(i_wr_num_trans), .o_wr_busy(o_wr_busy), .o_ctrl_write_done(o_ctrl_write_done),
    .i_abort(i_abort), .dma_if(dma_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_cfg(input logic [31:0] base, input logic [15:0] nb, input logic [15:0] nr,
                        input logic [31:0] bs, input logic [31:0] rs);
    i_rd_base_addr = base; i_rd_num_blk = nb; i_rd_num_row = nr;
    i_rd_blk_stride = bs;  i_rd_row_stride = rs;
  endtask

  task automatic wr_cfg(input logic [31:0] base, input logic [15:0] nb, input logic [15:0] nr,
                        input logic [31:0] bs, input logic [31:0] rs, input logic [17:0] nt);
    i_wr_base_addr = base; i_wr_num_blk = nb; i_wr_num_row = nr;
    i_wr_blk_stride = bs;  i_wr_row_stride = rs; i_wr_num_trans = nt;
  endtask

  // Pulse the burst done, then count cycles (bounded) until the next request shows up
  task automatic rd_done_wait(output int cyc);
    dma_if.read_done = 1'b1;
    tick();
    dma_if.read_done = 1'b0;
    cyc = 1;
    while (!dma_if.ctrl_read && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wr_done_wait(output int cyc);
    dma_if.write_done = 1'b1;
    tick();
    dma_if.write_done = 1'b0;
    cyc = 1;
    while (!dma_if.ctrl_write && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rstn = 1'b0;
    i_rd_start = 1'b0; i_wr_start = 1'b0; i_abort = 1'b0;
    rd_cfg(32'h0, 16'd0, 16'd0, 32'h0, 32'h0);
    wr_cfg(32'h0, 16'd0, 16'd0, 32'h0, 32'h0, 18'd0);
    dma_if.read_done = 1'b0; dma_if.write_done = 1'b0; dma_if.indata_req_wr = 1'b0;
    wr_exp[0] = 32'h000; wr_exp[1] = 32'h010; wr_exp[2] = 32'h100; wr_exp[3] = 32'h110;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_busy", o_rd_busy, 0);
    chk("rst_wr_busy", o_wr_busy, 0);
    chk("rst_ctrl_read", dma_if.ctrl_read, 0);
    chk("rst_ctrl_write", dma_if.ctrl_write, 0);
    chk("rst_read_addr", dma_if.read_addr, 0);
    chk("rst_write_addr", dma_if.write_addr, 0);
    chk("rst_data_cnt", dma_if.write_data_cnt, 0);
    chk("rst_done", {o_ctrl_read_done, o_ctrl_write_done}, 0);
    rstn = 1'b1;
    tick();

    // 1D read, 4 blocks, 0x40 stride
    rd_cfg(32'h1000, 16'd4, 16'd1, 32'h40, 32'h0);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    rd_cfg(32'hDEAD, 16'd9, 16'd9, 32'h4, 32'h4);
    chk("rd1_first_req", dma_if.ctrl_read, 1);
    chk("rd1_addr0", dma_if.read_addr, 32'h1000);
    chk("rd1_busy", o_rd_busy, 1);
    tick();
    chk("rd1_req_one_cycle", dma_if.ctrl_read, 0);
    for (int k = 1; k < 4; k++) begin
      rd_done_wait(n);
      chk("rd1_spacing", n, 4);
      chk("rd1_addr", dma_if.read_addr, 32'h1000 + 32'h40 * k);
      chk("rd1_no_done", o_ctrl_read_done, 0);
      tick();
    end
    dma_if.read_done = 1'b1;
    tick();
    dma_if.read_done = 1'b0;
    chk("rd1_done_pulse", o_ctrl_read_done, 1);
    chk("rd1_no_req_at_done", dma_if.ctrl_read, 0);
    tick();
    chk("rd1_done_low", o_ctrl_read_done, 0);
    chk("rd1_idle", o_rd_busy, 0);

    // 2D write, 2x2
    wr_cfg(32'h0, 16'd2, 16'd2, 32'h10, 32'h100, 18'd4);
    i_wr_start = 1'b1;
    tick();
    i_wr_start = 1'b0;
    chk("wr2d_req0", dma_if.ctrl_write, 1);
    chk("wr2d_addr0", dma_if.write_addr, wr_exp[0]);
    tick();
    for (int k = 1; k < 4; k++) begin
      wr_done_wait(n);
      chk("wr2d_spacing", n, 4);
      chk("wr2d_addr", dma_if.write_addr, wr_exp[k]);
      chk("wr2d_no_done", o_ctrl_write_done, 0);
      tick();
    end
    dma_if.write_done = 1'b1;
    tick();
    dma_if.write_done = 1'b0;
    chk("wr2d_done_pulse", o_ctrl_write_done, 1);
    tick();
    chk("wr2d_done_single", o_ctrl_write_done, 0);
    chk("wr2d_idle", o_wr_busy, 0);

    // Zero-length read
    rd_cfg(32'h2000, 16'd3, 16'd0, 32'h40, 32'h0);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    chk("zl_done", o_ctrl_read_done, 1);
    chk("zl_busy", o_rd_busy, 1);
    chk("zl_no_req", dma_if.ctrl_read, 0);
    tick();
    chk("zl_done_low", o_ctrl_read_done, 0);
    chk("zl_idle", o_rd_busy, 0);
    chk("zl_no_req2", dma_if.ctrl_read, 0);

    // Concurrent planes and write beat counter
    rd_cfg(32'h2000, 16'd1, 16'd1, 32'h0, 32'h0);
    wr_cfg(32'h600, 16'd2, 16'd1, 32'h10, 32'h0, 18'd16);
    i_rd_start = 1'b1; i_wr_start = 1'b1;
    tick();
    i_rd_start = 1'b0; i_wr_start = 1'b0;
    chk("cc_both_req", {dma_if.ctrl_read, dma_if.ctrl_write}, 2'b11);
    tick();
    for (int i = 0; i < 20; i++) begin
      dma_if.indata_req_wr = 1'b1;
      chk("cc_data_cnt", dma_if.write_data_cnt, i % 16);
      tick();
    end
    dma_if.indata_req_wr = 1'b0;
    chk("cc_data_cnt_end", dma_if.write_data_cnt, 4);
    chk("cc_rd_still_busy", o_rd_busy, 1);
    chk("cc_rd_addr", dma_if.read_addr, 32'h2000);
    dma_if.read_done = 1'b1;
    tick();
    dma_if.read_done = 1'b0;
    chk("cc_rd_done", o_ctrl_read_done, 1);
    chk("cc_wr_no_done", o_ctrl_write_done, 0);
    tick();
    chk("cc_rd_idle", o_rd_busy, 0);
    chk("cc_wr_busy", o_wr_busy, 1);
    wr_done_wait(n);
    chk("cc_wr_spacing", n, 4);
    chk("cc_wr_addr1", dma_if.write_addr, 32'h610);
    tick();
    chk("cc_cnt_cleared", dma_if.write_data_cnt, 0);
    dma_if.write_done = 1'b1;
    tick();
    dma_if.write_done = 1'b0;
    chk("cc_wr_done", o_ctrl_write_done, 1);
    tick();

    // Abort during WAIT of read block 2, with a done in the same cycle
    rd_cfg(32'h3000, 16'd4, 16'd1, 32'h40, 32'h0);
    wr_cfg(32'h4000, 16'd4, 16'd1, 32'h40, 32'h0, 18'd8);
    i_rd_start = 1'b1; i_wr_start = 1'b1;
    tick();
    i_rd_start = 1'b0; i_wr_start = 1'b0;
    tick();
    rd_done_wait(n);
    tick();
    rd_done_wait(n);
    chk("ab_addr_blk2", dma_if.read_addr, 32'h3080);
    tick();
    i_abort = 1'b1; dma_if.read_done = 1'b1;
    tick();
    i_abort = 1'b0; dma_if.read_done = 1'b0;
    chk("ab_busy_low", {o_rd_busy, o_wr_busy}, 2'b00);
    chk("ab_no_done", {o_ctrl_read_done, o_ctrl_write_done}, 2'b00);
    chk("ab_addr_cleared", dma_if.read_addr, 0);
    tick();
    chk("ab_no_done_later", {o_ctrl_read_done, o_ctrl_write_done}, 2'b00);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    chk("ab_restart_req", dma_if.ctrl_read, 1);
    chk("ab_restart_addr", dma_if.read_addr, 32'h3000);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;

    // Address wrap and ignored start while busy
    rd_cfg(32'hFFFFFFC0, 16'd2, 16'd1, 32'h40, 32'h0);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    chk("wrap_addr0", dma_if.read_addr, 32'hFFFFFFC0);
    tick();
    rd_cfg(32'h5000, 16'd1, 16'd1, 32'h0, 32'h0);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    chk("busy_start_no_req", dma_if.ctrl_read, 0);
    chk("busy_start_addr", dma_if.read_addr, 32'hFFFFFFC0);
    rd_done_wait(n);
    chk("wrap_spacing", n, 4);
    chk("wrap_addr1", dma_if.read_addr, 32'h0);
    tick();
    dma_if.read_done = 1'b1;
    tick();
    dma_if.read_done = 1'b0;
    chk("wrap_done", o_ctrl_read_done, 1);
    tick();

    // Reset asserted mid-GAP clears outputs without a clock edge
    rd_cfg(32'h100, 16'd2, 16'd1, 32'h20, 32'h0);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    tick();
    dma_if.read_done = 1'b1;
    tick();
    dma_if.read_done = 1'b0;
    tick();
    chk("gap_addr_advanced", dma_if.read_addr, 32'h120);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", o_rd_busy, 0);
    chk("rst_mid_addr", dma_if.read_addr, 0);
    chk("rst_mid_ctrl", {dma_if.ctrl_read, o_ctrl_read_done}, 0);
    tick();
    rstn = 1'b1;
    repeat (6) tick();
    chk("rst_mid_stays_idle", {o_rd_busy, dma_if.ctrl_read}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
